fpalu_req_scheduler: RTL

//  Shares one 32-bit FP add/multiply ALU among NREQ requesters. Each requester uses a valid/ready request channel.

---
 rtl/fpalu_pkg.sv | 20 ++
 rtl/fpalu_rr_pick.sv | 39 +++
 rtl/fpalu_req_scheduler.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/fpalu_pkg.sv
// Shared constants and types for the FP ALU request scheduler.
// FSM state encoding, FP word width and op codes used by the top and its helpers.
package fpalu_pkg;

    localparam int FP_W = 32;

    localparam logic FP_OP_ADD = 1'b0;
    localparam logic FP_OP_MUL = 1'b1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_EXEC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    typedef struct packed {
        logic [FP_W-1:0] a;
        logic [FP_W-1:0] b;
        logic            op;
    } fp_req_t;

endpackage

// File: rtl/fpalu_rr_pick.sv
// Combinational round-robin picker: first set request bit at or after ptr_i,
// wrapping from NREQ-1 back to 0.
module fpalu_rr_pick #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  ptr_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IDW-1:0]  idx_o,
    output logic            any_o
);

    int j_s;

    // Scan from the pointer forward, wrapping, and keep only the first hit
    always_comb begin
        gnt_o = '0;
        idx_o = '0;
        any_o = 1'b0;
        j_s   = 0;
        for (int k = 0; k < NREQ; k++) begin
            j_s = int'(ptr_i) + k;
            if (j_s >= NREQ) begin
                j_s = j_s - NREQ;
            end else begin
                j_s = j_s;
            end
            if (!any_o && req_i[j_s]) begin
                any_o      = 1'b1;
                gnt_o[j_s] = 1'b1;
                idx_o      = IDW'(j_s);
            end else begin
                any_o = any_o;
            end
        end
    end

endmodule

// File: rtl/fpalu_req_scheduler.sv
// Round-robin scheduler sharing one FP add/mul ALU among NREQ requesters.
// Optional per-requester sticky overflow flags: define FPALU_SCHED_OVF_STICKY_EN.
module fpalu_req_scheduler
    import fpalu_pkg::*;
#(
    parameter int NREQ    = 4,
    parameter int ALU_LAT = 1,
    parameter int IDW     = ($clog2(NREQ) > 1) ? $clog2(NREQ) : 1
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [NREQ-1:0]      req_valid,
    output logic [NREQ-1:0]      req_ready,
    input  logic [NREQ*FP_W-1:0] req_a,
    input  logic [NREQ*FP_W-1:0] req_b,
    input  logic [NREQ-1:0]      req_op,
    output logic                 resp_valid,
    input  logic                 resp_ready,
    output logic [IDW-1:0]       resp_id,
    output logic [FP_W-1:0]      resp_result,
    output logic                 resp_overflow,
    output logic [FP_W-1:0]      alu_a,
    output logic [FP_W-1:0]      alu_b,
    output logic                 alu_op,
    input  logic [FP_W-1:0]      alu_result,
    input  logic                 alu_overflow,
`ifdef FPALU_SCHED_OVF_STICKY_EN
    output logic [NREQ-1:0]      ovf_sticky,
    input  logic [NREQ-1:0]      ovf_clr,
`endif
    output logic                 busy
);

    localparam int LATW = (ALU_LAT > 1) ? $clog2(ALU_LAT) : 1;

    logic [1:0]      state_q, state_d;
    logic [IDW-1:0]  rr_ptr_q, rr_ptr_d;
    logic [LATW-1:0] lat_cnt_q, lat_cnt_d;
    fp_req_t         op_q, op_d;
    logic [IDW-1:0]  id_q, id_d;
    logic [FP_W-1:0] res_q, res_d;
    logic            rovf_q, rovf_d;
    logic            resp_valid_q, busy_q;

    logic [NREQ-1:0] pick_gnt_s;
    logic [IDW-1:0]  pick_idx_s;
    logic            pick_any_s;
    logic            cap_s;

    fpalu_rr_pick #(.NREQ(NREQ), .IDW(IDW)) u_pick (
        .req_i (req_valid),
        .ptr_i (rr_ptr_q),
        .gnt_o (pick_gnt_s),
        .idx_o (pick_idx_s),
        .any_o (pick_any_s)
    );

    assign cap_s = (state_q == ST_EXEC) && (lat_cnt_q == '0);

    // Next-state logic: grant in IDLE, count latency in EXEC, hold response in RESP
    always_comb begin
        state_d   = state_q;
        rr_ptr_d  = rr_ptr_q;
        lat_cnt_d = lat_cnt_q;
        op_d      = op_q;
        id_d      = id_q;
        res_d     = res_q;
        rovf_d    = rovf_q;
        req_ready = '0;
        case (state_q)
            ST_IDLE: begin
                if (pick_any_s) begin
                    req_ready = pick_gnt_s;
                    op_d.a    = req_a[FP_W*int'(pick_idx_s) +: FP_W];
                    op_d.b    = req_b[FP_W*int'(pick_idx_s) +: FP_W];
                    op_d.op   = req_op[pick_idx_s];
                    id_d      = pick_idx_s;
                    rr_ptr_d  = (pick_idx_s == IDW'(NREQ-1)) ? '0 : pick_idx_s + 1'b1;
                    lat_cnt_d = LATW'(ALU_LAT-1);
                    state_d   = ST_EXEC;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_EXEC: begin
                if (cap_s) begin
                    res_d   = alu_result;
                    rovf_d  = alu_overflow;
                    state_d = ST_RESP;
                end else begin
                    lat_cnt_d = lat_cnt_q - 1'b1;
                end
            end
            ST_RESP: begin
                if (resp_ready) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State, operand and response registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            rr_ptr_q     <= '0;
            lat_cnt_q    <= '0;
            op_q         <= '{a: 32'h0000_0000, b: 32'h0000_0000, op: FP_OP_ADD};
            id_q         <= '0;
            res_q        <= 32'h0000_0000;
            rovf_q       <= 1'b0;
            resp_valid_q <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            rr_ptr_q     <= rr_ptr_d;
            lat_cnt_q    <= lat_cnt_d;
            op_q         <= op_d;
            id_q         <= id_d;
            res_q        <= res_d;
            rovf_q       <= rovf_d;
            resp_valid_q <= (state_d == ST_RESP);
            busy_q       <= (state_d != ST_IDLE);
        end
    end

    assign alu_a         = op_q.a;
    assign alu_b         = op_q.b;
    assign alu_op        = op_q.op;
    assign resp_valid    = resp_valid_q;
    assign resp_id       = id_q;
    assign resp_result   = res_q;
    assign resp_overflow = rovf_q;
    assign busy          = busy_q;

`ifdef FPALU_SCHED_OVF_STICKY_EN
    logic [NREQ-1:0] sticky_q, sticky_d;

    // Clear first so a same-cycle set on the captured requester wins
    always_comb begin
        sticky_d = sticky_q & ~ovf_clr;
        if (cap_s && alu_overflow) begin
            sticky_d[id_q] = 1'b1;
        end else begin
            sticky_d = sticky_d;
        end
    end

    // Sticky overflow register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign ovf_sticky = sticky_q;
`endif

endmodule
